// File: rtl/ltc_scan_sequencer.sv
// Multi-channel LTC2986 conversion sequencer: start, poll with timeout, read result,
// and stream each result out on a valid/ready interface.
module ltc_scan_sequencer #(
    parameter int NUM_CH    = 4,
    parameter int FIRST_CH  = 1,
    parameter int POLL_GAP  = 1000,
    parameter int MAX_POLLS = 255,
    parameter int SCAN_GAP  = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        scan_start,
    input  logic        continuous,
    output logic [7:0]  tx0,
    output logic [7:0]  tx1,
    output logic [7:0]  tx2,
    output logic [7:0]  tx3,
    output logic [7:0]  tx4,
    output logic [7:0]  tx5,
    output logic [7:0]  tx6,
    output logic [2:0]  spi_n,
    output logic        spi_go,
    input  logic [7:0]  rx0,
    input  logic [7:0]  rx1,
    input  logic [7:0]  rx2,
    input  logic [7:0]  rx3,
    input  logic [7:0]  rx4,
    input  logic [7:0]  rx5,
    input  logic [7:0]  rx6,
    input  logic        spi_ok,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [4:0]  res_ch,
    output logic [23:0] res_data,
    output logic [7:0]  res_fault,
    output logic        res_timeout,
    output logic        scan_busy,
    output logic        scan_done
);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] POLL_WAIT = 3'd2;
    localparam logic [2:0] POLL      = 3'd3;
    localparam logic [2:0] READ      = 3'd4;
    localparam logic [2:0] EMIT      = 3'd5;
    localparam logic [2:0] SCAN_WAIT = 3'd6;

    localparam logic [4:0]  FIRST      = 5'(FIRST_CH);
    localparam logic [4:0]  LAST       = 5'(FIRST_CH + NUM_CH - 1);
    localparam logic [31:0] POLL_LAST  = 32'(POLL_GAP - 1);
    localparam logic [31:0] SCAN_LAST  = 32'(SCAN_GAP - 1);
    localparam logic [31:0] POLL_LIMIT = 32'(MAX_POLLS);
    localparam logic [55:0] POLL_FRAME = {8'h03, 48'h0};

    function automatic logic [55:0] start_frame(input logic [4:0] c);
        return {8'h02, 8'h00, 8'h00, 3'b100, c, 24'h0};
    endfunction

    // Result registers are 4 bytes apart starting at 0x010 for channel 1.
    function automatic logic [55:0] read_frame(input logic [4:0] c);
        logic [15:0] addr;
        addr = 16'h0010 + {9'd0, c - 5'd1, 2'b00};
        return {8'h03, addr, 32'h0};
    endfunction

    logic [2:0]  state_reg;
    logic [4:0]  ch_reg;
    logic [31:0] gap_cnt_reg;
    logic [31:0] poll_cnt_reg;
    logic        issued_reg;
    logic [55:0] frame_reg;
    logic [2:0]  spi_n_reg;
    logic        spi_go_reg;
    logic        res_valid_reg;
    logic [4:0]  res_ch_reg;
    logic [23:0] res_data_reg;
    logic [7:0]  res_fault_reg;
    logic        res_timeout_reg;
    logic        scan_busy_reg;
    logic        scan_done_reg;

    logic        launch;
    logic [55:0] launch_frame;
    logic [2:0]  launch_n;
    logic        status_match;
    logic        unused_rx;

    assign unused_rx    = ^{rx0, rx1, rx2};
    assign status_match = rx3[6] && (rx3[4:0] == ch_reg);

    // A transaction is launched on the edge that enters its state, except the
    // first START of a scan, which launches one cycle after entry.
    always_comb begin
        launch       = 1'b0;
        launch_frame = POLL_FRAME;
        launch_n     = 3'd4;
        case (state_reg)
            START: if (!issued_reg) begin
                launch       = 1'b1;
                launch_frame = start_frame(ch_reg);
            end
            POLL_WAIT: launch = (gap_cnt_reg == POLL_LAST);
            POLL: if (issued_reg && spi_ok && status_match) begin
                launch       = 1'b1;
                launch_frame = read_frame(ch_reg);
                launch_n     = 3'd7;
            end
            EMIT: if (res_ready && ch_reg != LAST) begin
                launch       = 1'b1;
                launch_frame = start_frame(ch_reg + 5'd1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            ch_reg          <= 5'd0;
            gap_cnt_reg     <= 32'd0;
            poll_cnt_reg    <= 32'd0;
            issued_reg      <= 1'b0;
            frame_reg       <= 56'h0;
            spi_n_reg       <= 3'd0;
            spi_go_reg      <= 1'b0;
            res_valid_reg   <= 1'b0;
            res_ch_reg      <= 5'd0;
            res_data_reg    <= 24'd0;
            res_fault_reg   <= 8'd0;
            res_timeout_reg <= 1'b0;
            scan_busy_reg   <= 1'b0;
            scan_done_reg   <= 1'b0;
        end else begin
            spi_go_reg    <= launch;
            scan_done_reg <= 1'b0;
            // spi_ok only counts while a launched transaction is outstanding.
            issued_reg    <= launch || (issued_reg && !spi_ok);
            if (launch) begin
                frame_reg <= launch_frame;
                spi_n_reg <= launch_n;
            end
            case (state_reg)
                IDLE: if (scan_start || continuous) begin
                    ch_reg        <= FIRST;
                    scan_busy_reg <= 1'b1;
                    state_reg     <= START;
                end
                START: if (issued_reg && spi_ok) begin
                    poll_cnt_reg <= 32'd0;
                    gap_cnt_reg  <= 32'd0;
                    state_reg    <= POLL_WAIT;
                end
                POLL_WAIT: begin
                    if (gap_cnt_reg == POLL_LAST) state_reg <= POLL;
                    else gap_cnt_reg <= gap_cnt_reg + 32'd1;
                end
                POLL: if (issued_reg && spi_ok) begin
                    if (status_match) begin
                        state_reg <= READ;
                    end else if (poll_cnt_reg + 32'd1 == POLL_LIMIT) begin
                        res_ch_reg      <= ch_reg;
                        res_data_reg    <= 24'd0;
                        res_fault_reg   <= 8'd0;
                        res_timeout_reg <= 1'b1;
                        res_valid_reg   <= 1'b1;
                        state_reg       <= EMIT;
                    end else begin
                        poll_cnt_reg <= poll_cnt_reg + 32'd1;
                        gap_cnt_reg  <= 32'd0;
                        state_reg    <= POLL_WAIT;
                    end
                end
                READ: if (issued_reg && spi_ok) begin
                    res_ch_reg      <= ch_reg;
                    res_fault_reg   <= rx3;
                    res_data_reg    <= {rx4, rx5, rx6};
                    res_timeout_reg <= 1'b0;
                    res_valid_reg   <= 1'b1;
                    state_reg       <= EMIT;
                end
                EMIT: if (res_ready) begin
                    res_valid_reg <= 1'b0;
                    if (ch_reg != LAST) begin
                        ch_reg    <= ch_reg + 5'd1;
                        state_reg <= START;
                    end else begin
                        scan_done_reg <= 1'b1;
                        scan_busy_reg <= 1'b0;
                        gap_cnt_reg   <= 32'd0;
                        state_reg     <= continuous ? SCAN_WAIT : IDLE;
                    end
                end
                SCAN_WAIT: begin
                    if (!continuous) begin
                        state_reg <= IDLE;
                    end else if (gap_cnt_reg == SCAN_LAST) begin
                        ch_reg        <= FIRST;
                        scan_busy_reg <= 1'b1;
                        state_reg     <= START;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + 32'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign {tx0, tx1, tx2, tx3, tx4, tx5, tx6} = frame_reg;
    assign spi_n       = spi_n_reg;
    assign spi_go      = spi_go_reg;
    assign res_valid   = res_valid_reg;
    assign res_ch      = res_ch_reg;
    assign res_data    = res_data_reg;
    assign res_fault   = res_fault_reg;
    assign res_timeout = res_timeout_reg;
    assign scan_busy   = scan_busy_reg;
    assign scan_done   = scan_done_reg;
endmodule

// File: tb/tb_ltc_scan_sequencer.sv
// Bench for ltc_scan_sequencer: per-channel SPI response table, an SPI engine model
// feeding a result scoreboard, and directed sequences for stall, continuous and reset.
module tb_ltc_scan_sequencer;
    localparam int NUM_CH    = 3;
    localparam int FIRST_CH  = 18;
    localparam int POLL_GAP  = 4;
    localparam int MAX_POLLS = 3;
    localparam int SCAN_GAP  = 20;
    localparam int LAT       = 3;

    logic clk, reset, scan_start, continuous, spi_go, spi_ok;
    logic [7:0] tx0, tx1, tx2, tx3, tx4, tx5, tx6;
    logic [7:0] rx0, rx1, rx2, rx3, rx4, rx5, rx6;
    logic [2:0] spi_n;
    logic res_valid, res_ready, res_timeout, scan_busy, scan_done;
    logic [4:0] res_ch;
    logic [23:0] res_data;
    logic [7:0] res_fault;

    typedef struct {
        logic [4:0]  ch;     // channel expected in this START
        int          fails;  // polls answered not-done before done
        logic [7:0]  bad;    // status byte used for not-done polls
        bit          to;     // never completes -> timeout
        logic [7:0]  addr;   // expected low address byte of READ
        logic [7:0]  fault;
        logic [23:0] data;
    } vec_t;

    typedef struct packed {
        logic [4:0]  ch;
        logic [7:0]  fault;
        logic [23:0] data;
        logic        to;
    } exp_t;

    vec_t vec[16];
    exp_t exp_q[$];
    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int done_cnt = 0;
    int go_cnt = 0;

    ltc_scan_sequencer #(
        .NUM_CH(NUM_CH), .FIRST_CH(FIRST_CH), .POLL_GAP(POLL_GAP),
        .MAX_POLLS(MAX_POLLS), .SCAN_GAP(SCAN_GAP)
    ) dut (
        .clk(clk), .reset(reset), .scan_start(scan_start), .continuous(continuous),
        .tx0(tx0), .tx1(tx1), .tx2(tx2), .tx3(tx3), .tx4(tx4), .tx5(tx5), .tx6(tx6),
        .spi_n(spi_n), .spi_go(spi_go),
        .rx0(rx0), .rx1(rx1), .rx2(rx2), .rx3(rx3), .rx4(rx4), .rx5(rx5), .rx6(rx6),
        .spi_ok(spi_ok), .res_valid(res_valid), .res_ready(res_ready),
        .res_ch(res_ch), .res_data(res_data), .res_fault(res_fault),
        .res_timeout(res_timeout), .scan_busy(scan_busy), .scan_done(scan_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (scan_done) done_cnt <= done_cnt + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [4:0] ch, input int fails, input logic [7:0] bad,
                                input bit to, input logic [7:0] addr, input logic [7:0] fault,
                                input logic [23:0] data);
        vec_t v;
        v.ch = ch; v.fails = fails; v.bad = bad; v.to = to;
        v.addr = addr; v.fault = fault; v.data = data;
        return v;
    endfunction

    // SPI engine model: answers each launched transaction after LAT cycles from the
    // next table record, and queues the result the sequencer must emit.
    task automatic spi_model();
        logic [55:0] f;
        logic [2:0]  n;
        logic [31:0] rsp;
        int idx, polls, last_ok;
        vec_t r;
        bit aborted;
        exp_t e;
        idx = -1; polls = 0; last_ok = 0; r = vec[0];
        forever begin
            @(negedge clk);
            if (spi_ok) begin
                spi_ok = 1'b0;
                {rx3, rx4, rx5, rx6} = 32'h0;
            end
            if (spi_go && !reset) begin
                f = {tx0, tx1, tx2, tx3, tx4, tx5, tx6};
                n = spi_n;
                go_cnt++;
                rsp = 32'h0;
                if (f[55:48] == 8'h02) begin
                    idx++;
                    if (idx > 15) idx = 15;
                    r = vec[idx];
                    polls = 0;
                    check("start_frame", {n, f}, {3'd4, 8'h02, 16'h0, 8'h80 | {3'b000, r.ch}, 24'h0});
                end else if (n == 3'd4) begin
                    polls++;
                    check("poll_frame", {n, f}, {3'd4, 8'h03, 48'h0});
                    check("poll_gap", ((cyc - last_ok) >= POLL_GAP + 1), 1);
                    check("poll_limit", (polls <= MAX_POLLS), 1);
                    if (r.to || polls <= r.fails) rsp[31:24] = r.bad;
                    else rsp[31:24] = 8'h40 | {3'b000, r.ch};
                    if (r.to && polls == MAX_POLLS) begin
                        e.ch = r.ch; e.fault = 8'h00; e.data = 24'h0; e.to = 1'b1;
                        exp_q.push_back(e);
                    end
                end else begin
                    check("read_frame", {n, f}, {3'd7, 8'h03, 8'h00, r.addr, 32'h0});
                    rsp = {r.fault, r.data};
                    e.ch = r.ch; e.fault = r.fault; e.data = r.data; e.to = 1'b0;
                    exp_q.push_back(e);
                end
                aborted = 1'b0;
                for (int k = 0; k < LAT; k++) begin
                    @(negedge clk);
                    if (reset) begin
                        aborted = 1'b1;
                        break;
                    end
                    check("go_one_cycle", spi_go, 0);
                    check("tx_hold", {spi_n, tx0, tx1, tx2, tx3, tx4, tx5, tx6}, {n, f});
                end
                if (!aborted) begin
                    {rx3, rx4, rx5, rx6} = rsp;
                    spi_ok = 1'b1;
                    last_ok = cyc;
                end
            end
        end
    endtask

    task automatic consume(input int stall, input bit last, output int done_at);
        exp_t e;
        int t;
        logic [37:0] held;
        done_at = 0;
        if (stall > 0) res_ready = 1'b0;
        t = 0;
        while (!res_valid && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (!res_valid) begin
            check("res_valid_wait", res_valid, 1);
            res_ready = 1'b1;
            return;
        end
        if (stall > 0) begin
            held = {res_ch, res_fault, res_data, res_timeout};
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                check("stall_hold", {res_valid, res_ch, res_fault, res_data, res_timeout}, {1'b1, held});
                check("stall_no_go", spi_go, 0);
            end
            res_ready = 1'b1;
        end
        if (exp_q.size() == 0) begin
            check("sb_nonempty", exp_q.size(), 1);
        end else begin
            e = exp_q.pop_front();
            check("res_ch", res_ch, e.ch);
            check("res_fault", res_fault, e.fault);
            check("res_data", res_data, e.data);
            check("res_timeout", res_timeout, e.to);
        end
        @(negedge clk);
        if (last) begin
            check("scan_done_pulse", scan_done, 1);
            check("busy_after_last", scan_busy, 0);
            done_at = cyc;
            @(negedge clk);
            check("scan_done_one_cycle", scan_done, 0);
        end else begin
            check("valid_drops", res_valid, 0);
            check("go_after_accept", spi_go, 1);
        end
    endtask

    task automatic wait_go(input bit want_read, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (spi_go && (!want_read || spi_n == 3'd7)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, {spi_go, spi_n, tx0, tx1, tx2, tx3, tx4, tx5, tx6, res_valid, res_ch,
                     res_data, res_fault, res_timeout, scan_busy, scan_done}, 0);
    endtask

    initial begin
        int d, g, go0;
        bit ok;
        vec[0]  = mk(5'd18, 1, 8'h00, 0, 8'h54, 8'h01, 24'h123456);
        vec[1]  = mk(5'd19, 2, 8'h52, 0, 8'h58, 8'h00, 24'hABCDEF);
        vec[2]  = mk(5'd20, 0, 8'h00, 0, 8'h5C, 8'h80, 24'h000001);
        vec[3]  = mk(5'd18, 0, 8'h92, 1, 8'h54, 8'h00, 24'h000000);
        vec[4]  = mk(5'd19, 0, 8'h00, 0, 8'h58, 8'h02, 24'h7FFFFF);
        vec[5]  = mk(5'd20, 1, 8'h14, 0, 8'h5C, 8'h00, 24'h800000);
        vec[6]  = mk(5'd18, 0, 8'h00, 0, 8'h54, 8'h11, 24'h111111);
        vec[7]  = mk(5'd19, 1, 8'h00, 0, 8'h58, 8'h22, 24'h222222);
        vec[8]  = mk(5'd20, 0, 8'h00, 0, 8'h5C, 8'h33, 24'h333333);
        vec[9]  = mk(5'd18, 0, 8'h00, 0, 8'h54, 8'h44, 24'h444444);
        vec[10] = mk(5'd19, 0, 8'h00, 0, 8'h58, 8'h55, 24'h555555);
        vec[11] = mk(5'd20, 2, 8'h53, 0, 8'h5C, 8'h66, 24'h666666);
        vec[12] = mk(5'd18, 0, 8'h00, 0, 8'h54, 8'h77, 24'h777777);
        vec[13] = mk(5'd18, 1, 8'h00, 0, 8'h54, 8'h88, 24'h888888);
        vec[14] = mk(5'd19, 0, 8'h00, 0, 8'h58, 8'h99, 24'h999999);
        vec[15] = mk(5'd20, 0, 8'h00, 0, 8'h5C, 8'hAA, 24'hAAAAAA);

        reset = 1'b1; scan_start = 1'b0; continuous = 1'b0; res_ready = 1'b1; spi_ok = 1'b0;
        {rx0, rx1, rx2, rx3, rx4, rx5, rx6} = 56'h0;
        fork
            spi_model();
        join_none
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_state");
        reset = 1'b0;
        @(negedge clk);

        // Single shot; a second scan_start while busy must be ignored.
        scan_start = 1'b1;
        @(negedge clk);
        scan_start = 1'b0;
        check("start_latency_n1", spi_go, 0);
        check("busy_after_start", scan_busy, 1);
        @(negedge clk);
        check("start_latency_n2", spi_go, 1);
        consume(0, 0, d);
        scan_start = 1'b1;
        @(negedge clk);
        scan_start = 1'b0;
        consume(0, 0, d);
        consume(0, 1, d);
        go0 = go_cnt;
        repeat (50) @(negedge clk);
        check("idle_no_go", go_cnt, go0);
        check("idle_not_busy", scan_busy, 0);
        check("done_count_a", done_cnt, 1);

        // Timeout on the first channel, back-pressure on the second.
        scan_start = 1'b1;
        @(negedge clk);
        scan_start = 1'b0;
        consume(0, 0, d);
        consume(50, 0, d);
        consume(0, 1, d);

        // Continuous: two scans, continuous dropped during the second.
        continuous = 1'b1;
        for (int i = 0; i < NUM_CH; i++) consume(0, (i == NUM_CH - 1), d);
        wait_go(0, ok);
        check("rescan_go", ok, 1);
        g = cyc;
        check("scan_gap", ((g - d) >= SCAN_GAP + 1), 1);
        check("rescan_busy", scan_busy, 1);
        consume(0, 0, d);
        continuous = 1'b0;
        consume(0, 0, d);
        consume(0, 1, d);
        go0 = go_cnt;
        repeat (60) @(negedge clk);
        check("cont_stop_no_go", go_cnt, go0);
        check("cont_stop_idle", scan_busy, 0);
        check("done_count_c", done_cnt, 4);

        // Reset during a READ, then a clean scan.
        scan_start = 1'b1;
        @(negedge clk);
        scan_start = 1'b0;
        wait_go(1, ok);
        check("read_go_seen", ok, 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_reset_outputs("reset_mid_read");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        scan_start = 1'b1;
        @(negedge clk);
        scan_start = 1'b0;
        for (int i = 0; i < NUM_CH; i++) consume(0, (i == NUM_CH - 1), d);
        check("sb_drained", exp_q.size(), 0);
        check("done_count_d", done_cnt, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
